pc_ctrl: RTL and testbench
==========================

Name: pc_ctrl

Overview:
Next-PC sequencer and front-end hazard controller for the 5-stage pipeline. It sits beside the PC register. It drives the PC write enable and next-PC value, plus the IF/ID write and flush controls and the ID/EX bubble control. It arbitrates between start-up, data-memory stall, load-use hazard, ID-stage branch redirect and sequential fetch. It also keeps saturating event counters for performance debug.

Parameters:
XLEN, 32, PC/address width
RESET_VEC, 32'h0000_0000, PC value driven while idle
INSTR_BYTES, 4, sequential PC increment
CNT_W, 16, width of each event counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  run enable; low forces the idle state
mem_stall_i  in  1  data-cache miss stall; freezes the whole pipeline
load_use_i  in  1  load-use hazard detected in ID
branch_taken_i  in  1  branch/jump resolved taken in ID
branch_target_i  in  XLEN  redirect target from ID
pc_i  in  XLEN  current PC register value
pc_next_o  out  XLEN  value to load into the PC
pc_write_o  out  1  PC load enable
if_id_write_o  out  1  IF/ID register enable
if_id_flush_o  out  1  IF/ID register flush (insert NOP)
id_ex_bubble_o  out  1  zero ID/EX control fields
stall_cnt_o  out  CNT_W  mem-stall cycle count
flush_cnt_o  out  CNT_W  redirect flush count
bubble_cnt_o  out  CNT_W  load-use bubble count

Behaviour:
- FSM states are IDLE, RUN and HOLD. Reset (rst_i=0) puts the FSM in IDLE, clears the pending-redirect register (pend_v=0, pend_tgt=0) and clears all counters.
- All control outputs are combinational from the state and inputs. The counters and pending register are the only other flops.
- IDLE outputs: pc_next_o=RESET_VEC, pc_write_o=1, if_id_write_o=1, if_id_flush_o=1, id_ex_bubble_o=1. These are also the output values while reset is held.
- IDLE transitions: start_i=1 goes to RUN, which fetches from RESET_VEC on the next cycle.
- start_i=0 in any state: next state is IDLE and pend_v is cleared. The IDLE outputs apply in the same cycle, overriding all other rules.
- RUN priority, highest first:
  1. mem_stall_i=1: pc_write_o=0, if_id_write_o=0, flush=0, bubble=0. Next state is HOLD. If branch_taken_i=1 in this cycle, capture pend_v=1 and pend_tgt=branch_target_i.
  2. load_use_i=1: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1. Any branch in this cycle is ignored because its operands are not yet valid.
  3. branch_taken_i=1: pc_next_o=branch_target_i, pc_write_o=1, if_id_flush_o=1, if_id_write_o=1.
  4. Otherwise: pc_next_o=pc_i+INSTR_BYTES, wrapping modulo 2^XLEN, pc_write_o=1, if_id_write_o=1.
- HOLD while mem_stall_i=1: same outputs as RUN rule 1, with no new capture. pend_tgt is held.
- HOLD when mem_stall_i falls: this cycle evaluates as RUN, except that when pend_v=1 the pending redirect replaces branch_taken_i and branch_target_i. The live branch inputs are ignored, so the same branch is not redirected twice. pend_v clears, and the next state is RUN.
- load_use_i in the HOLD exit cycle still has priority. In that case pend_v stays set until a cycle with no load-use.
- When pc_write_o=0, pc_next_o equals pc_i (no X).
- Counters saturate at all-ones and never wrap:
  - stall_cnt_o increments on every cycle with mem_stall_i=1 in RUN or HOLD.
  - flush_cnt_o increments on every cycle with if_id_flush_o=1 outside IDLE.
  - bubble_cnt_o increments on every load-use bubble cycle.
- Reset asserted mid-operation returns everything to the reset values immediately (asynchronous reset). A redirect that is pending at that point is lost.

Decomposition:
- Shared package pc_ctrl_pkg holds the pc_state_e enum (IDLE, RUN, HOLD), XLEN, INSTR_BYTES and the default RESET_VEC.
- One sub-module, sat_counter (parameter W; ports clk_i, rst_i, inc_i, cnt_o), instantiated three times.

Test Plan:
- Reset, then start_i=1 with pc_i=0 → cycle 1: pc_next_o=0, flush=1. Next cycle: pc_next_o=4, pc_write_o=1, flush=0.
- pc_i=32'hFFFF_FFFC in RUN with no hazards → pc_next_o=0 (wrap), pc_write_o=1.
- Scenario 3, branch in RUN:
  - branch_taken_i=1, target=32'h40, pc_i=32'h10 → pc_next_o=32'h40, pc_write_o=1, if_id_flush_o=1, flush_cnt_o increments by 1.
  - Same branch with load_use_i=1 → pc_write_o=0, id_ex_bubble_o=1, no flush, bubble_cnt_o increments by 1.
- Scenario 4, branch together with a mem stall:
  - mem_stall_i=1 for 3 cycles, with branch_taken_i=1 and target=32'h80 in the first cycle → pc_write_o=0 for all 3 cycles and stall_cnt_o=3.
  - In the exit cycle: pc_next_o=32'h80, flush=1.
  - A live branch_taken_i with target 32'hC0 during the exit cycle is ignored.
- start_i dropped during HOLD with pend_v=1 → pc_next_o=RESET_VEC in the same cycle, state IDLE, pend_v=0. Re-start does not replay the redirect.
- CNT_W=2: hold mem_stall_i for 6 cycles → stall_cnt_o=3 and stays at 3. Assert rst_i=0 mid-stall → all counters 0, state IDLE.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared types and defaults for the next-PC sequencer / front-end hazard controller.
package pc_ctrl_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_VEC_DEFAULT = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_ctrl.sv
// Next-PC selection and IF/ID, ID/EX hazard controls, plus saturating event counters.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN        = pc_ctrl_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VEC   = RESET_VEC_DEFAULT,
  parameter int unsigned     INSTR_BYTES = pc_ctrl_pkg::INSTR_BYTES,
  parameter int unsigned     CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mem_stall_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic [XLEN-1:0]  branch_target_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic [XLEN-1:0]  pc_next_o,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  pc_state_e       state_q, state_d;
  logic            pend_v_q, pend_v_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            stall_inc, flush_inc, bubble_inc;
  logic            eff_taken;
  logic [XLEN-1:0] eff_tgt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // A redirect captured under a stall stands in for the live branch inputs,
  // so the same branch is never redirected twice.
  assign eff_taken = pend_v_q | branch_taken_i;
  assign eff_tgt   = pend_v_q ? pend_tgt_q : branch_target_i;

  always_comb begin
    state_d        = state_q;
    pend_v_d       = pend_v_q;
    pend_tgt_d     = pend_tgt_q;
    pc_next_o      = pc_i;
    pc_write_o     = 1'b0;
    if_id_write_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    bubble_inc     = 1'b0;

    if (!start_i || (state_q == IDLE)) begin
      pc_next_o      = RESET_VEC;
      pc_write_o     = 1'b1;
      if_id_write_o  = 1'b1;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
      pend_v_d       = 1'b0;
      state_d        = start_i ? RUN : IDLE;
    end else if (mem_stall_i) begin
      stall_inc = 1'b1;
      state_d   = HOLD;
      if ((state_q == RUN) && branch_taken_i && !pend_v_q) begin
        pend_v_d   = 1'b1;
        pend_tgt_d = branch_target_i;
      end
    end else begin
      state_d = RUN;
      if (load_use_i) begin
        id_ex_bubble_o = 1'b1;
        bubble_inc     = 1'b1;
      end else if (eff_taken) begin
        pc_next_o     = eff_tgt;
        pc_write_o    = 1'b1;
        if_id_write_o = 1'b1;
        if_id_flush_o = 1'b1;
        flush_inc     = 1'b1;
        pend_v_d      = 1'b0;
      end else begin
        pc_next_o     = pc_i + XLEN'(INSTR_BYTES);
        pc_write_o    = 1'b1;
        if_id_write_o = 1'b1;
        pend_v_d      = 1'b0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bubble_inc),
    .cnt_o (bubble_cnt_o)
  );

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl: a default-width instance plus a 2-bit-counter instance on shared inputs.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        lu = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] pc = '0;

  logic [31:0] pc_next, s_pc_next;
  logic        pc_wr, ifid_wr, flush, bubble;
  logic        s_pc_wr, s_ifid_wr, s_flush, s_bubble;
  logic [15:0] stall_cnt, flush_cnt, bubble_cnt;
  logic [1:0]  s_stall_cnt, s_flush_cnt, s_bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mem_stall_i(stall),
    .load_use_i(lu), .branch_taken_i(br), .branch_target_i(tgt), .pc_i(pc),
    .pc_next_o(pc_next), .pc_write_o(pc_wr), .if_id_write_o(ifid_wr),
    .if_id_flush_o(flush), .id_ex_bubble_o(bubble),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .bubble_cnt_o(bubble_cnt)
  );

  pc_ctrl #(.CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mem_stall_i(stall),
    .load_use_i(lu), .branch_taken_i(br), .branch_target_i(tgt), .pc_i(pc),
    .pc_next_o(s_pc_next), .pc_write_o(s_pc_wr), .if_id_write_o(s_ifid_wr),
    .if_id_flush_o(s_flush), .id_ex_bubble_o(s_bubble),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt), .bubble_cnt_o(s_bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic [31:0] e_next, input logic e_wr,
                          input logic e_ifid, input logic e_flush, input logic e_bub);
    #1;
    chk({tag, ".pc_next"}, pc_next, e_next);
    chk({tag, ".pc_write"}, {31'd0, pc_wr}, {31'd0, e_wr});
    chk({tag, ".if_id_write"}, {31'd0, ifid_wr}, {31'd0, e_ifid});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
    chk({tag, ".bubble"}, {31'd0, bubble}, {31'd0, e_bub});
  endtask

  initial begin
    // Reset held: IDLE outputs, counters clear
    #2;
    chk_ctrl("reset", 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset.flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("reset.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);

    // Start: first cycle still IDLE, fetch RESET_VEC
    tick();
    rst = 1'b1;
    start = 1'b1;
    pc = 32'h0;
    chk_ctrl("start_c1", 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk_ctrl("start_c2", 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);

    // Sequential wrap
    pc = 32'hFFFF_FFFC;
    chk_ctrl("wrap", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Branch in RUN
    tick();
    pc = 32'h10; br = 1'b1; tgt = 32'h40;
    chk_ctrl("branch", 32'h40, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("branch.flush_cnt", {16'd0, flush_cnt}, 32'd1);

    // Branch masked by load-use
    lu = 1'b1;
    chk_ctrl("lu_branch", 32'h10, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("lu.bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
    chk("lu.flush_cnt", {16'd0, flush_cnt}, 32'd1);

    // Stall 3 cycles with branch captured in the first
    lu = 1'b0; stall = 1'b1; br = 1'b1; tgt = 32'h80; pc = 32'h20;
    chk_ctrl("stall1", 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    br = 1'b0;
    chk_ctrl("stall2", 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_ctrl("stall3", 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stall.stall_cnt", {16'd0, stall_cnt}, 32'd3);
    chk("stall.sat_cnt", {30'd0, s_stall_cnt}, 32'd3);

    // Exit: pending redirect wins over live branch to C0
    stall = 1'b0; br = 1'b1; tgt = 32'hC0;
    chk_ctrl("hold_exit", 32'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    br = 1'b0;
    chk_ctrl("after_exit", 32'h24, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("exit.flush_cnt", {16'd0, flush_cnt}, 32'd2);

    // Drop start during HOLD with a pending redirect
    stall = 1'b1; br = 1'b1; tgt = 32'h200; pc = 32'h30;
    tick();
    chk("drop.stall_cnt", {16'd0, stall_cnt}, 32'd4);
    br = 1'b0; start = 1'b0;
    chk_ctrl("drop", 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    start = 1'b1; stall = 1'b0; pc = 32'h0;
    chk_ctrl("restart_c1", 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk_ctrl("restart_no_replay", 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);

    // Load-use on HOLD exit keeps the redirect pending
    stall = 1'b1; br = 1'b1; tgt = 32'h300; pc = 32'h50;
    tick();
    stall = 1'b0; br = 1'b0; lu = 1'b1;
    chk_ctrl("exit_lu", 32'h50, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    lu = 1'b0; br = 1'b1; tgt = 32'h500;
    chk_ctrl("pend_after_lu", 32'h300, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    br = 1'b0;
    chk_ctrl("pend_cleared", 32'h54, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu2.bubble_cnt", {16'd0, bubble_cnt}, 32'd2);
    chk("lu2.stall_cnt", {16'd0, stall_cnt}, 32'd5);

    // Saturation on the 2-bit instance over 6 stall cycles
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sat.stall_cnt", {30'd0, s_stall_cnt}, 32'd3);
    end
    chk("sat.wide_stall_cnt", {16'd0, stall_cnt}, 32'd11);

    // Asynchronous reset mid-stall
    #2;
    rst = 1'b0;
    chk_ctrl("async_rst", 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst.sat_stall", {30'd0, s_stall_cnt}, 32'd0);
    chk("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst.flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("rst.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
    tick();
    rst = 1'b1; stall = 1'b0;
    chk_ctrl("post_rst_idle", 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
